matrix_ram_arbiter: RTL

- Round-robin arbiter that shares the single read/write port (port A) of the 32x32-word matrix RAM between NUM_REQ requesters: the DMA loader, the pivot search unit and the elimination engine.
- Registers the winning access onto the RAM port.
- Tracks in-flight reads with a tag pipeline and returns read data to the requester that issued each read.

---
 rtl/matrix_ram_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/matrix_ram_arbiter.sv
// Round-robin arbiter sharing matrix RAM port A between NUM_REQ requesters, with read-tag return path.
// Optional requester lock for read-modify-write sequences is enabled by defining ARB_LOCK_EN.
module matrix_ram_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int RAM_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data,
  output logic                      ram_we,
  input  logic [DATA_W-1:0]         ram_q
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W:0]   sum;
  logic             found;
  logic             xfer;
  tag_t             new_tag;
  tag_t             tag_pipe [RAM_LATENCY];

`ifdef ARB_LOCK_EN
  logic             lock_active;
  logic [IDX_W-1:0] lock_idx;
`endif

  // Scan from the start index upward with wrap; a held lock pins the start on its owner.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    start   = ptr;
    found   = 1'b0;
    win_idx = '0;
    sum     = '0;
    gnt     = '0;
`ifdef ARB_LOCK_EN
    if (lock_active && req[lock_idx] && lock[lock_idx]) start = lock_idx;
`endif
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, start} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      if (!found && req[sum[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = sum[IDX_W-1:0];
      end
    end
    if (found && !reset) gnt[win_idx] = 1'b1;
  end

  assign xfer     = found && !reset;
  assign next_ptr = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign rdata    = ram_q;

  always_comb begin
    new_tag.valid = xfer && !req_we[win_idx];
    new_tag.idx   = win_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      rvalid   <= '0;
      ptr      <= '0;
      // NOTE: the tag pipeline is reset because its valid bits must not
      // survive a reset; a plain data array would be left unreset.
      for (int s = 0; s < RAM_LATENCY; s++) tag_pipe[s] <= '0;
`ifdef ARB_LOCK_EN
      lock_active <= 1'b0;
      lock_idx    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      ram_we <= 1'b0;
      if (xfer) begin
        ram_we   <= req_we[win_idx];
        ram_addr <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        ram_data <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
        ptr      <= next_ptr;
      end
      tag_pipe[0] <= new_tag;
      for (int s = 1; s < RAM_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
      // The final stage is the rvalid register itself, giving RAM_LATENCY+1 stages in total.
      rvalid <= '0;
      if (tag_pipe[RAM_LATENCY-1].valid) rvalid[tag_pipe[RAM_LATENCY-1].idx] <= 1'b1;
`ifdef ARB_LOCK_EN
      lock_active <= xfer && lock[win_idx];
      if (xfer) lock_idx <= win_idx;
`endif
    end
  end

endmodule
